// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: IDLE/RUN/LAP/PAUSE sequencing from two button pulses,
// BCD mm:ss.cc counting on the 0.01 s strobe, and a display that freezes on lap.
module stopwatch_ctrl #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_001,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       tmr_clr,
    output logic       run,
    output logic       lap_hold,
    output logic       ovf,
    output logic [7:0] dsp_cs,
    output logic [7:0] dsp_sec,
    output logic [7:0] dsp_min
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [7:0] MIN_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

    state_t      state_reg, state_next;
    // Count layout, LSD first: cs units, cs tens, sec units, sec tens, min units, min tens.
    logic [23:0] cnt_reg, cnt_next, cnt_inc;
    logic [23:0] lap_reg, lap_next;
    logic        tmr_clr_reg, tmr_clr_next;
    logic        ovf_reg, ovf_next;
    logic [5:0]  digit_max;
    logic [5:0]  carry_in;
    logic        wrap;
    logic        count_en;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi == 3) ? 4'd5 : 4'd9;
            logic [3:0] digit;
            assign digit         = cnt_reg[4*gi +: 4];
            assign digit_max[gi] = (digit == LIM);
            if (gi == 0) begin : g_lsd
                assign carry_in[gi] = 1'b1;
            end else begin : g_upper
                assign carry_in[gi] = &digit_max[gi-1:0];
            end
            assign cnt_inc[4*gi +: 4] = !carry_in[gi] ? digit
                                      : (digit_max[gi] ? 4'd0 : digit + 4'd1);
        end
    endgenerate

    // The minute field wraps at MIN_MAX rather than at its BCD digit limits.
    assign wrap     = (cnt_reg[23:16] == MIN_BCD) && (cnt_reg[15:0] == 16'h5999);
    assign count_en = tick_001 && ((state_reg == RUN) || (state_reg == LAP));

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        lap_next     = lap_reg;
        tmr_clr_next = 1'b0;
        ovf_next     = 1'b0;

        if (count_en) begin
            if (wrap) begin
                cnt_next = 24'h0;
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_inc;
            end
        end

        // btn_ss is tested first everywhere, so it wins over a coincident btn_lr.
        case (state_reg)
            IDLE: begin
                if (btn_ss) begin
                    state_next   = RUN;
                    tmr_clr_next = 1'b1;
                end
            end
            RUN: begin
                if (btn_ss) begin
                    state_next = PAUSE;
                end else if (btn_lr) begin
                    state_next = LAP;
                    lap_next   = cnt_reg;
                end
            end
            LAP: begin
                if (btn_ss) begin
                    state_next = PAUSE;
                end else if (btn_lr) begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (btn_ss) begin
                    state_next = RUN;
                end else if (btn_lr) begin
                    state_next = IDLE;
                    cnt_next   = 24'h0;
                    lap_next   = 24'h0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 24'h0;
            lap_reg     <= 24'h0;
            tmr_clr_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            lap_reg     <= lap_next;
            tmr_clr_reg <= tmr_clr_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign tmr_clr  = tmr_clr_reg;
    assign ovf      = ovf_reg;
    assign run      = (state_reg == RUN) || (state_reg == LAP);
    assign lap_hold = (state_reg == LAP);
    assign dsp_cs   = lap_hold ? lap_reg[7:0]   : cnt_reg[7:0];
    assign dsp_sec  = lap_hold ? lap_reg[15:8]  : cnt_reg[15:8];
    assign dsp_min  = lap_hold ? lap_reg[23:16] : cnt_reg[23:16];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (MIN_MAX=1 so the wrap is reachable quickly).
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_001;
    logic       btn_ss;
    logic       btn_lr;
    logic       tmr_clr;
    logic       run;
    logic       lap_hold;
    logic       ovf;
    logic [7:0] dsp_cs;
    logic [7:0] dsp_sec;
    logic [7:0] dsp_min;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.MIN_MAX(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_001 (tick_001),
        .btn_ss   (btn_ss),
        .btn_lr   (btn_lr),
        .tmr_clr  (tmr_clr),
        .run      (run),
        .lap_hold (lap_hold),
        .ovf      (ovf),
        .dsp_cs   (dsp_cs),
        .dsp_sec  (dsp_sec),
        .dsp_min  (dsp_min)
    );

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Inputs set before step() are sampled on that edge; outputs read afterwards reflect it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        tick_001 = 1'b1;
        repeat (n) step();
        tick_001 = 1'b0;
    endtask

    function automatic logic [23:0] dsp();
        return {dsp_min, dsp_sec, dsp_cs};
    endfunction

    initial begin
        rst = 1'b0; tick_001 = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;

        // 1: reset with inputs toggling
        for (int i = 0; i < 3; i++) begin
            tick_001 = i[0]; btn_ss = ~i[0]; btn_lr = 1'b1;
            step();
        end
        tick_001 = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;
        check("rst_dsp", dsp(), 24'h000000);
        check("rst_run", {23'd0, run}, 24'd0);
        check("rst_lap_hold", {23'd0, lap_hold}, 24'd0);
        check("rst_ovf", {23'd0, ovf}, 24'd0);
        check("rst_tmr_clr", {23'd0, tmr_clr}, 24'd0);
        rst = 1'b1;
        btn_lr = 1'b1; step(); btn_lr = 1'b0;
        check("idle_ignores_lr", {23'd0, run}, 24'd0);

        // 2: start then 150 ticks
        btn_ss = 1'b1; step(); btn_ss = 1'b0;
        check("start_tmr_clr", {23'd0, tmr_clr}, 24'd1);
        check("start_run", {23'd0, run}, 24'd1);
        step();
        check("tmr_clr_one_cycle", {23'd0, tmr_clr}, 24'd0);
        do_ticks(150);
        check("run_150", dsp(), 24'h000150);

        // 3: lap freeze and release
        do_ticks(87);
        check("run_237", dsp(), 24'h000237);
        btn_lr = 1'b1; step(); btn_lr = 1'b0;
        check("lap_enter_hold", {23'd0, lap_hold}, 24'd1);
        do_ticks(100);
        check("lap_frozen", dsp(), 24'h000237);
        check("lap_run", {23'd0, run}, 24'd1);
        btn_lr = 1'b1; step(); btn_lr = 1'b0;
        check("lap_release", dsp(), 24'h000337);
        check("lap_release_hold", {23'd0, lap_hold}, 24'd0);

        // 4: pause with coincident tick, dropped ticks, simultaneous buttons, clear
        btn_ss = 1'b1; tick_001 = 1'b1; step(); btn_ss = 1'b0; tick_001 = 1'b0;
        check("pause_tick_counted", dsp(), 24'h000338);
        check("pause_run", {23'd0, run}, 24'd0);
        do_ticks(5);
        check("pause_ticks_dropped", dsp(), 24'h000338);
        btn_ss = 1'b1; btn_lr = 1'b1; tick_001 = 1'b1; step();
        btn_ss = 1'b0; btn_lr = 1'b0; tick_001 = 1'b0;
        check("both_btn_resume_run", {23'd0, run}, 24'd1);
        check("both_btn_no_clear", dsp(), 24'h000338);
        check("resume_no_tmr_clr", {23'd0, tmr_clr}, 24'd0);
        btn_ss = 1'b1; step(); btn_ss = 1'b0;
        btn_lr = 1'b1; step(); btn_lr = 1'b0;
        check("clear_dsp", dsp(), 24'h000000);
        check("clear_run", {23'd0, run}, 24'd0);

        // 5: wrap past 01:59.99
        btn_ss = 1'b1; step(); btn_ss = 1'b0;
        do_ticks(11999);
        check("pre_wrap", dsp(), 24'h015999);
        do_ticks(1);
        check("wrap_dsp", dsp(), 24'h000000);
        check("wrap_ovf", {23'd0, ovf}, 24'd1);
        check("wrap_run", {23'd0, run}, 24'd1);
        step();
        check("ovf_one_cycle", {23'd0, ovf}, 24'd0);

        // 6: reset mid-lap
        do_ticks(4512);
        check("run_4512", dsp(), 24'h004512);
        btn_lr = 1'b1; step(); btn_lr = 1'b0;
        do_ticks(10);
        check("lap_4512", dsp(), 24'h004512);
        rst = 1'b0; tick_001 = 1'b1; btn_ss = 1'b1; step();
        rst = 1'b1; tick_001 = 1'b0; btn_ss = 1'b0;
        check("midlap_rst_dsp", dsp(), 24'h000000);
        check("midlap_rst_hold", {23'd0, lap_hold}, 24'd0);
        check("midlap_rst_run", {23'd0, run}, 24'd0);
        btn_ss = 1'b1; step(); btn_ss = 1'b0;
        check("restart_tmr_clr", {23'd0, tmr_clr}, 24'd1);
        check("restart_dsp", dsp(), 24'h000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
